// File: rtl/l2_pkg.sv
// Shared types and width helpers for the L2 (sum of squared errors) stream engine.
package l2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } l2_state_t;

  function automatic int num_width(input int size);
    return $clog2(size + 1);
  endfunction

  // Wide enough for SIZE full-scale squared differences without wrapping.
  function automatic int acc_width(input int w, input int size);
    return 2 * w + 2 + $clog2(size);
  endfunction

endpackage

// File: rtl/l2_lane_sq.sv
// One lane: (a - b)^2 in signed fixed point, rescaled by FL with floor rounding.
module l2_lane_sq #(
  parameter int W  = 20,
  parameter int FL = 12
) (
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic signed [2*W+1:0]   p
);

  logic signed [W:0]     d;
  logic signed [2*W+1:0] dx;
  logic signed [2*W+1:0] sq;

  assign d  = {a[W-1], a} - {b[W-1], b};
  assign dx = {{(W+1){d[W]}}, d};
  assign sq = dx * dx;
  assign p  = sq >>> FL;

endmodule

// File: rtl/l2_stream.sv
// L2 loss over up to SIZE fixed-point elements, LANES per cycle.
// Define L2_SAT_EN to saturate sum to the max positive value on overflow.
module l2_stream
  import l2_pkg::*;
#(
  parameter int IL    = 8,
  parameter int FL    = 12,
  parameter int SIZE  = 16,
  parameter int LANES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [num_width(SIZE)-1:0]      num,
  input  logic [SIZE*(IL+FL)-1:0]         yHat,
  input  logic [SIZE*(IL+FL)-1:0]         y,
  output logic                            busy,
  output logic                            done,
  output logic signed [IL+FL-1:0]         sum,
  output logic                            overflow
);

  localparam int W  = IL + FL;
  localparam int NW = num_width(SIZE);
  localparam int AW = acc_width(W, SIZE);
  localparam int PW = 2 * W + 2;
  localparam int EW = $clog2(SIZE);
  localparam logic [NW-1:0] SIZE_N  = NW'(SIZE);
  localparam logic [NW-1:0] LANES_N = NW'(LANES);
  localparam logic [AW-1:0] MAXPOS  = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};

  l2_state_t state;
  logic [NW-1:0]        num_q;
  logic [NW-1:0]        idx;
  logic signed [W-1:0]  yh_q [SIZE];
  logic signed [W-1:0]  y_q  [SIZE];
  logic signed [PW-1:0] lane_p [LANES];
  logic signed [PW-1:0] lane_q [LANES];
  logic [EW-1:0]        lane_el [LANES];
  logic                 lane_valid [LANES];
  logic signed [AW-1:0] lane_total;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic [NW-1:0]        num_in;
  logic                 accept;
  logic                 acc_ovf;

  assign busy     = (state == RUN) || (state == DRAIN);
  assign accept   = (state == IDLE) && start && !done;
  assign num_in   = (num > SIZE_N) ? SIZE_N : num;
  assign acc_next = acc + lane_total;
  assign acc_ovf  = $unsigned(acc_next) > MAXPOS;

  // Element index wraps harmlessly past SIZE; such lanes are masked invalid.
  always_comb begin
    for (int unsigned j = 0; j < LANES; j++) begin
      lane_el[j]    = '0;
      lane_valid[j] = 1'b0;
    end
    for (int unsigned j = 0; j < LANES; j++) begin
      lane_el[j]    = EW'({1'b0, idx} + (NW+1)'(j));
      lane_valid[j] = ({1'b0, idx} + (NW+1)'(j)) < {1'b0, num_q};
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    l2_lane_sq #(.W(W), .FL(FL)) u_lane (
      .a (yh_q[lane_el[j]]),
      .b (y_q[lane_el[j]]),
      .p (lane_p[j])
    );
  end

  always_comb begin
    lane_total = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      lane_total = lane_total + AW'(lane_q[j]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned j = 0; j < LANES; j++) lane_q[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < LANES; j++)
        lane_q[j] <= (state == RUN && lane_valid[j]) ? lane_p[j] : '0;
    end
  end

  // RUN keeps going one cycle past the last element so the lane stage drains
  // into the accumulator before DRAIN publishes the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      num_q    <= '0;
      idx      <= '0;
      acc      <= '0;
      done     <= 1'b0;
      sum      <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        yh_q[i] <= '0;
        y_q[i]  <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
              yh_q[i] <= yHat[i*W +: W];
              y_q[i]  <= y[i*W +: W];
            end
            num_q    <= num_in;
            idx      <= '0;
            acc      <= '0;
            overflow <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (idx >= num_q) state <= DRAIN;
          else              idx   <= idx + LANES_N;
        end
        DRAIN: begin
          acc      <= acc_next;
          state    <= IDLE;
          done     <= 1'b1;
          overflow <= acc_ovf;
`ifdef L2_SAT_EN
          sum      <= acc_ovf ? MAXPOS[W-1:0] : acc_next[W-1:0];
`else
          sum      <= acc_next[W-1:0];
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
